// File: rtl/xadac_pkg.sv
// Shared types and sizing for the xadac accelerator path, including the
// vector register file stage's request/response records.
package xadac_pkg;

  localparam int unsigned NoVec    = 32;
  localparam int unsigned VecWidth = 256;
  localparam int unsigned NoVs     = 3;
  localparam int unsigned SbLen    = 8;

  typedef logic [VecWidth-1:0]      VecT;
  typedef logic [$clog2(NoVec)-1:0] RegAddrT;
  typedef logic [$clog2(SbLen)-1:0] IdT;
  typedef logic [31:0]              InstrT;
  typedef logic [31:0]              DataT;

  typedef struct packed {
    IdT    id;
    InstrT instr;
  } xadac_dec_req_t;

  typedef struct packed {
    IdT   id;
    logic accept;
  } xadac_dec_rsp_t;

  typedef struct packed {
    IdT    id;
    InstrT instr;
    DataT  rs1_data;
  } xadac_exe_req_t;

  typedef struct packed {
    IdT   id;
    DataT rd_data;
    logic rd_write;
  } xadac_exe_rsp_t;

  typedef struct packed {
    IdT               id;
    InstrT            instr;
    DataT             rs1_data;
    VecT [NoVs-1:0]   vs_data;
  } xadac_vrf_exe_req_t;

  typedef struct packed {
    IdT   id;
    DataT rd_data;
    logic rd_write;
    logic vd_write;
    VecT  vd_data;
  } xadac_vrf_exe_rsp_t;

  // Source operand order: vs1, vs2, then vs3 which shares the vd field.
  function automatic RegAddrT src_addr(input InstrT instr, input int idx);
    case (idx)
      0:       return instr[19:15];
      1:       return instr[24:20];
      default: return instr[11:7];
    endcase
  endfunction

  function automatic RegAddrT vd_addr(input InstrT instr);
    return instr[11:7];
  endfunction

endpackage

// File: rtl/xadac_if.sv
// Accelerator handshake bundle: decode and execute request/response channels.
interface xadac_if;
  import xadac_pkg::*;

  xadac_dec_req_t dec_req;
  logic           dec_req_valid;
  logic           dec_req_ready;
  xadac_dec_rsp_t dec_rsp;
  logic           dec_rsp_valid;
  logic           dec_rsp_ready;
  xadac_exe_req_t exe_req;
  logic           exe_req_valid;
  logic           exe_req_ready;
  xadac_exe_rsp_t exe_rsp;
  logic           exe_rsp_valid;
  logic           exe_rsp_ready;

  modport mst (
    output dec_req, dec_req_valid, dec_rsp_ready, exe_req, exe_req_valid, exe_rsp_ready,
    input  dec_req_ready, dec_rsp, dec_rsp_valid, exe_req_ready, exe_rsp, exe_rsp_valid
  );

  modport slv (
    input  dec_req, dec_req_valid, dec_rsp_ready, exe_req, exe_req_valid, exe_rsp_ready,
    output dec_req_ready, dec_rsp, dec_rsp_valid, exe_req_ready, exe_rsp, exe_rsp_valid
  );
endinterface

// File: rtl/xadac_vrf_if.sv
// Accelerator bundle below the register file: execute channels carry vector data.
interface xadac_vrf_if;
  import xadac_pkg::*;

  xadac_dec_req_t     dec_req;
  logic               dec_req_valid;
  logic               dec_req_ready;
  xadac_dec_rsp_t     dec_rsp;
  logic               dec_rsp_valid;
  logic               dec_rsp_ready;
  xadac_vrf_exe_req_t exe_req;
  logic               exe_req_valid;
  logic               exe_req_ready;
  xadac_vrf_exe_rsp_t exe_rsp;
  logic               exe_rsp_valid;
  logic               exe_rsp_ready;

  modport mst (
    output dec_req, dec_req_valid, dec_rsp_ready, exe_req, exe_req_valid, exe_rsp_ready,
    input  dec_req_ready, dec_rsp, dec_rsp_valid, exe_req_ready, exe_rsp, exe_rsp_valid
  );

  modport slv (
    input  dec_req, dec_req_valid, dec_rsp_ready, exe_req, exe_req_valid, exe_rsp_ready,
    output dec_req_ready, dec_rsp, dec_rsp_valid, exe_req_ready, exe_rsp, exe_rsp_valid
  );
endinterface

// File: rtl/xadac_vrf_array.sv
// Vector register storage: three asynchronous read ports, one write port,
// whole array cleared by reset.
module xadac_vrf_array
  import xadac_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  RegAddrT [NoVs-1:0]   raddr,
  output VecT     [NoVs-1:0]   rdata,
  input  logic                 we,
  input  RegAddrT              waddr,
  input  VecT                  wdata
);

  VecT [NoVec-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // NOTE: the array is flop-based and must read as zero after reset, so it is
  // cleared like any other state; a RAM macro could not offer this.
  always_ff @(posedge clk) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  always_comb begin
    for (int i = 0; i < NoVs; i++) rdata[i] = mem_q[raddr[i]];
  end

endmodule

// File: rtl/xadac_vrf.sv
// Vector register file stage: attaches vs operands to execute requests,
// writes vd results back from execute responses, passes decode through.
module xadac_vrf
  import xadac_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  xadac_if.slv       slv,
  xadac_vrf_if.mst   mst
);

  logic                   stage_valid_q, stage_valid_d;
  xadac_vrf_exe_req_t     stage_q, stage_d;
  RegAddrT [SbLen-1:0]    vd_tbl_q, vd_tbl_d;

  logic                   req_ready;
  logic                   req_acc;
  logic                   rsp_wr;
  RegAddrT                wr_addr;
  RegAddrT [NoVs-1:0]     rd_addr;
  VecT     [NoVs-1:0]     rd_data;
  VecT     [NoVs-1:0]     vs_data;

  assign mst.dec_req       = slv.dec_req;
  assign mst.dec_req_valid = slv.dec_req_valid;
  assign slv.dec_req_ready = mst.dec_req_ready;
  assign slv.dec_rsp       = mst.dec_rsp;
  assign slv.dec_rsp_valid = mst.dec_rsp_valid;
  assign mst.dec_rsp_ready = slv.dec_rsp_ready;

  assign req_ready         = !stage_valid_q || mst.exe_req_ready;
  assign req_acc           = slv.exe_req_valid && req_ready;
  assign slv.exe_req_ready = req_ready;
  assign mst.exe_req_valid = stage_valid_q;
  assign mst.exe_req       = stage_q;

  assign slv.exe_rsp       = '{id:       mst.exe_rsp.id,
                               rd_data:  mst.exe_rsp.rd_data,
                               rd_write: mst.exe_rsp.rd_write};
  assign slv.exe_rsp_valid = mst.exe_rsp_valid;
  assign mst.exe_rsp_ready = slv.exe_rsp_ready;

  // The write target comes from the table before any same-cycle update, so a
  // response and a new request on the same id still retire the old vd.
  assign rsp_wr  = mst.exe_rsp_valid && slv.exe_rsp_ready && mst.exe_rsp.vd_write;
  assign wr_addr = vd_tbl_q[mst.exe_rsp.id];

  always_comb begin
    for (int i = 0; i < NoVs; i++) rd_addr[i] = src_addr(slv.exe_req.instr, i);
  end

  // Upstream frees a clobbered register in the same cycle its result returns,
  // so a reader accepted in that cycle must see the result, not the array.
  always_comb begin
    for (int i = 0; i < NoVs; i++) begin
      vs_data[i] = (rsp_wr && (rd_addr[i] == wr_addr)) ? mst.exe_rsp.vd_data : rd_data[i];
    end
  end

  xadac_vrf_array u_array (
    .clk   (clk),
    .rst   (rst),
    .raddr (rd_addr),
    .rdata (rd_data),
    .we    (rsp_wr),
    .waddr (wr_addr),
    .wdata (mst.exe_rsp.vd_data)
  );

  // NOTE: every signal gets its hold value first so no path leaves it
  // unassigned; that keeps this block purely combinational (no latches).
  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_d       = stage_q;
    vd_tbl_d      = vd_tbl_q;
    if (req_acc) begin
      stage_valid_d                        = 1'b1;
      stage_d.id                           = slv.exe_req.id;
      stage_d.instr                        = slv.exe_req.instr;
      stage_d.rs1_data                     = slv.exe_req.rs1_data;
      stage_d.vs_data                      = vs_data;
      vd_tbl_d[slv.exe_req.id]             = vd_addr(slv.exe_req.instr);
    end else if (mst.exe_req_ready) begin
      stage_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_q <= 1'b0;
      vd_tbl_q      <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      vd_tbl_q      <= vd_tbl_d;
    end
    stage_q <= stage_d;
  end

endmodule

// File: tb/tb_xadac_vrf.sv
// Self-checking bench for xadac_vrf: decode vector table, directed execute
// sequences, and randomized traffic against a queue/array reference model.
module tb_xadac_vrf;
  import xadac_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xadac_if     slv_if();
  xadac_vrf_if mst_if();

  xadac_vrf dut (
    .clk (clk),
    .rst (rst),
    .slv (slv_if),
    .mst (mst_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_xfer   = 0;

  VecT                m_vrf [NoVec];
  RegAddrT            m_vd  [SbLen];
  xadac_vrf_exe_req_t exp_q [$];

  typedef struct {
    xadac_dec_req_t req;     logic req_valid;     logic req_ready;
    xadac_dec_rsp_t rsp;     logic rsp_valid;     logic rsp_ready;
    xadac_dec_req_t exp_req; logic exp_req_valid; logic exp_req_ready;
    xadac_dec_rsp_t exp_rsp; logic exp_rsp_valid; logic exp_rsp_ready;
  } dec_vec_t;

  dec_vec_t dec_tbl [4];

  task automatic check(input string name, input logic [839:0] act, input logic [839:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else             n_pass++;
  endtask

  function automatic InstrT mk_instr(input RegAddrT s1, input RegAddrT s2, input RegAddrT d);
    return {7'h00, s2, s1, 3'b000, d, 7'h57};
  endfunction

  function automatic VecT rnd_vec();
    VecT v;
    for (int i = 0; i < VecWidth / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < NoVec; i++) m_vrf[i] = '0;
    for (int i = 0; i < SbLen; i++) m_vd[i] = '0;
  endtask

  task automatic idle();
    slv_if.dec_req_valid = 1'b0;  slv_if.dec_req = '0;  slv_if.dec_rsp_ready = 1'b1;
    mst_if.dec_rsp_valid = 1'b0;  mst_if.dec_rsp = '0;  mst_if.dec_req_ready = 1'b1;
    slv_if.exe_req_valid = 1'b0;  slv_if.exe_req = '0;
    mst_if.exe_req_ready = 1'b1;
    mst_if.exe_rsp_valid = 1'b0;  mst_if.exe_rsp = '0;
    slv_if.exe_rsp_ready = 1'b1;
  endtask

  task automatic set_req(input IdT id, input RegAddrT s1, input RegAddrT s2, input RegAddrT d);
    slv_if.exe_req_valid    = 1'b1;
    slv_if.exe_req.id       = id;
    slv_if.exe_req.instr    = mk_instr(s1, s2, d);
    slv_if.exe_req.rs1_data = $urandom();
  endtask

  task automatic set_rsp(input IdT id, input logic w, input VecT data);
    mst_if.exe_rsp_valid    = 1'b1;
    mst_if.exe_rsp.id       = id;
    mst_if.exe_rsp.rd_data  = $urandom();
    mst_if.exe_rsp.rd_write = 1'($urandom_range(0, 1));
    mst_if.exe_rsp.vd_write = w;
    mst_if.exe_rsp.vd_data  = data;
  endtask

  // One clock: inputs were set at the falling edge; check, predict, advance.
  task automatic step();
    logic               exp_rdy, acc, drain, wr;
    RegAddrT            waddr;
    RegAddrT            a [NoVs];
    VecT                wdata;
    xadac_vrf_exe_req_t nreq;
    xadac_exe_rsp_t     exp_rsp;
    #1;
    exp_rdy = (exp_q.size() == 0) || mst_if.exe_req_ready;
    check("slv_exe_req_ready", slv_if.exe_req_ready, exp_rdy);
    check("mst_exe_req_valid", mst_if.exe_req_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("mst_exe_req", mst_if.exe_req, exp_q[0]);
    exp_rsp = '{id: mst_if.exe_rsp.id, rd_data: mst_if.exe_rsp.rd_data,
                rd_write: mst_if.exe_rsp.rd_write};
    check("slv_exe_rsp_valid", slv_if.exe_rsp_valid, mst_if.exe_rsp_valid);
    check("slv_exe_rsp", slv_if.exe_rsp, exp_rsp);
    check("mst_exe_rsp_ready", mst_if.exe_rsp_ready, slv_if.exe_rsp_ready);
    if (mst_if.exe_req_valid && mst_if.exe_req_ready) n_xfer++;

    acc   = slv_if.exe_req_valid && exp_rdy;
    drain = (exp_q.size() != 0) && mst_if.exe_req_ready;
    wr    = mst_if.exe_rsp_valid && slv_if.exe_rsp_ready && mst_if.exe_rsp.vd_write;
    waddr = m_vd[mst_if.exe_rsp.id];
    wdata = mst_if.exe_rsp.vd_data;
    a[0]  = slv_if.exe_req.instr[19:15];
    a[1]  = slv_if.exe_req.instr[24:20];
    a[2]  = slv_if.exe_req.instr[11:7];
    nreq.id       = slv_if.exe_req.id;
    nreq.instr    = slv_if.exe_req.instr;
    nreq.rs1_data = slv_if.exe_req.rs1_data;
    for (int i = 0; i < NoVs; i++) nreq.vs_data[i] = (wr && a[i] == waddr) ? wdata : m_vrf[a[i]];

    @(posedge clk);
    if (rst) begin
      clear_model();
    end else begin
      if (drain) void'(exp_q.pop_front());
      if (acc)   exp_q.push_back(nreq);
      if (wr)    m_vrf[waddr] = wdata;
      if (acc)   m_vd[nreq.id] = nreq.instr[11:7];
    end
    @(negedge clk);
  endtask

  initial begin
    xadac_vrf_exe_req_t held;
    VecT                a5 = {32{8'hA5}};
    int                 x0;

    dec_tbl[0] = '{'{3'd1, 32'h0052_8057}, 1'b1, 1'b0, '{3'd2, 1'b1}, 1'b0, 1'b1,
                   '{3'd1, 32'h0052_8057}, 1'b1, 1'b0, '{3'd2, 1'b1}, 1'b0, 1'b1};
    dec_tbl[1] = '{'{3'd7, 32'hFFFF_FFFF}, 1'b0, 1'b1, '{3'd5, 1'b0}, 1'b1, 1'b0,
                   '{3'd7, 32'hFFFF_FFFF}, 1'b0, 1'b1, '{3'd5, 1'b0}, 1'b1, 1'b0};
    dec_tbl[2] = '{'{3'd0, 32'h1234_5678}, 1'b1, 1'b1, '{3'd3, 1'b1}, 1'b1, 1'b1,
                   '{3'd0, 32'h1234_5678}, 1'b1, 1'b1, '{3'd3, 1'b1}, 1'b1, 1'b1};
    dec_tbl[3] = '{'{3'd4, 32'hDEAD_BEEF}, 1'b0, 1'b0, '{3'd6, 1'b0}, 1'b0, 1'b0,
                   '{3'd4, 32'hDEAD_BEEF}, 1'b0, 1'b0, '{3'd6, 1'b0}, 1'b0, 1'b0};

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_model();

    // Decode pass-through vectors, 0-cycle latency.
    foreach (dec_tbl[k]) begin
      slv_if.dec_req       = dec_tbl[k].req;
      slv_if.dec_req_valid = dec_tbl[k].req_valid;
      mst_if.dec_req_ready = dec_tbl[k].req_ready;
      mst_if.dec_rsp       = dec_tbl[k].rsp;
      mst_if.dec_rsp_valid = dec_tbl[k].rsp_valid;
      slv_if.dec_rsp_ready = dec_tbl[k].rsp_ready;
      #1;
      check("dec_req",       mst_if.dec_req,       dec_tbl[k].exp_req);
      check("dec_req_valid", mst_if.dec_req_valid, dec_tbl[k].exp_req_valid);
      check("dec_req_ready", slv_if.dec_req_ready, dec_tbl[k].exp_req_ready);
      check("dec_rsp",       slv_if.dec_rsp,       dec_tbl[k].exp_rsp);
      check("dec_rsp_valid", slv_if.dec_rsp_valid, dec_tbl[k].exp_rsp_valid);
      check("dec_rsp_ready", mst_if.dec_rsp_ready, dec_tbl[k].exp_rsp_ready);
      @(negedge clk);
    end
    idle();

    // Reset state, then first request reads zeroed registers.
    check("reset_valid", mst_if.exe_req_valid, 1'b0);
    set_req(0, 1, 2, 3); step(); idle();
    check("first_valid", mst_if.exe_req_valid, 1'b1);
    for (int i = 0; i < NoVs; i++) check("first_vs_zero", mst_if.exe_req.vs_data[i], '0);

    // Write-back through vd table, read next cycle from the array.
    set_req(2, 0, 0, 5); step(); idle();
    set_rsp(2, 1'b1, a5); step(); idle();
    set_req(1, 5, 0, 6); step(); idle();
    check("wb_read_v5", mst_if.exe_req.vs_data[0], a5);

    // Same-cycle write and read: bypass.
    set_req(5, 0, 0, 7); step(); idle();
    set_rsp(5, 1'b1, VecT'(16'h1234)); set_req(6, 0, 7, 8); step(); idle();
    check("bypass_vs2", mst_if.exe_req.vs_data[1], VecT'(16'h1234));

    // Response without vd_write leaves v9 untouched.
    set_req(3, 0, 0, 9); step(); idle();
    set_rsp(3, 1'b0, '1); step(); idle();
    set_req(1, 9, 9, 9); step(); idle();
    check("no_write_v9", mst_if.exe_req.vs_data[0], '0);

    // Same-id collision: write retires old vd (10), table then holds 11.
    set_req(4, 0, 0, 10); step(); idle();
    set_rsp(4, 1'b1, VecT'(16'hBEEF)); set_req(4, 0, 0, 11); step(); idle();
    set_req(0, 10, 11, 0); step(); idle();
    check("collide_v10", mst_if.exe_req.vs_data[0], VecT'(16'hBEEF));
    check("collide_v11", mst_if.exe_req.vs_data[1], '0);
    set_rsp(4, 1'b1, VecT'(16'hCAFE)); step(); idle();
    set_req(0, 11, 0, 0); step(); idle();
    check("collide_v11_later", mst_if.exe_req.vs_data[0], VecT'(16'hCAFE));
    step();

    // Backpressure for 4 cycles, then 8 back-to-back transfers.
    mst_if.exe_req_ready = 1'b0;
    set_req(1, 5, 7, 12); step();
    set_req(2, 10, 11, 13);
    held = mst_if.exe_req;
    for (int c = 0; c < 4; c++) begin
      step();
      check("bp_slv_ready", slv_if.exe_req_ready, 1'b0);
      check("bp_stable", mst_if.exe_req, held);
    end
    mst_if.exe_req_ready = 1'b1;
    step();
    x0 = n_xfer;
    for (int c = 0; c < 8; c++) begin
      set_req(IdT'(c), RegAddrT'(c), RegAddrT'(c + 5), RegAddrT'(c + 16));
      step();
    end
    check("b2b_xfers", n_xfer - x0, 8);
    idle(); step();

    // Reset with the stage valid and v4 nonzero.
    set_req(6, 0, 0, 4); step(); idle();
    set_rsp(6, 1'b1, VecT'(16'h0077)); step(); idle();
    mst_if.exe_req_ready = 1'b0;
    set_req(7, 0, 0, 1); step();
    slv_if.exe_req_valid = 1'b0;
    check("pre_rst_valid", mst_if.exe_req_valid, 1'b1);
    rst = 1'b1; step(); rst = 1'b0; idle();
    check("post_rst_valid", mst_if.exe_req_valid, 1'b0);
    set_req(0, 4, 0, 0); step(); idle();
    check("post_rst_v4", mst_if.exe_req.vs_data[0], '0);
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      idle();
      if ($urandom_range(0, 3) != 0)
        set_req(IdT'($urandom()), RegAddrT'($urandom()), RegAddrT'($urandom()), RegAddrT'($urandom()));
      mst_if.exe_req_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) != 0)
        set_rsp(IdT'($urandom()), 1'($urandom_range(0, 1)), rnd_vec());
      slv_if.exe_rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    idle(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
